// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path: sample format,
// shared-arithmetic operand widths and the scheduler state encoding.
package synth_pkg;

  typedef logic signed [23:0] sample_t;

  localparam int MULT_W = 32;
  localparam int DIV_W  = 48;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    WAIT,
    OUT
  } sched_state_t;

endpackage

// File: rtl/voice_mux.sv
// N-way index mux for one shared operand bus. When en is low the output is 0,
// so the shared unit sees quiet operands outside a voice's slot.
module voice_mux #(
  parameter int N  = 3,
  parameter int W  = 32,
  parameter int IW = 2
) (
  input  logic [IW-1:0]  sel,
  input  logic           en,
  input  logic [N*W-1:0] data,
  output logic [W-1:0]   q
);

  always_comb begin
    q = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (sel == IW'(i)) q = data[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Per-sample sequencer: runs each enabled voice in turn on the shared
// multiplier/divider, sums their outputs and emits one saturated sample.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int N_VOICES = 3,
  parameter int OVR_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic [N_VOICES-1:0]       trig_in,
  input  logic [N_VOICES-1:0]       voice_en,
  output logic [N_VOICES-1:0]       voice_start,
  output logic [N_VOICES-1:0]       voice_trigger,
  input  logic [N_VOICES-1:0]       voice_finish,
  input  logic [N_VOICES*MULT_W-1:0] voice_mult_a,
  input  logic [N_VOICES*MULT_W-1:0] voice_mult_b,
  input  logic [N_VOICES*DIV_W-1:0]  voice_div_n,
  input  logic [N_VOICES*DIV_W-1:0]  voice_div_d,
  input  logic [N_VOICES*24-1:0]    voice_wave,
  output logic [MULT_W-1:0]         mult_a,
  output logic [MULT_W-1:0]         mult_b,
  output logic [DIV_W-1:0]          div_n,
  output logic [DIV_W-1:0]          div_d,
  output sample_t                   sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic [OVR_W-1:0]          overrun_count
);

  // idx must be able to hold N_VOICES itself, which marks the end of a frame.
  localparam int IW = $clog2(N_VOICES + 1);
  localparam int AW = 24 + $clog2(N_VOICES) + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(24'sh7FFFFF);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(24'sh800000);

  sched_state_t          state;
  logic [IW-1:0]         idx;
  logic signed [AW-1:0]  acc;
  logic [N_VOICES-1:0]   pending;
  logic [N_VOICES-1:0]   onehot;
  logic [N_VOICES-1:0]   clr;
  logic                  cur_en;
  logic                  cur_finish;
  sample_t               cur_wave;
  logic                  at_end;
  logic                  sel_en;
  sample_t               acc_sat;

  always_comb begin
    onehot     = '0;
    cur_en     = 1'b0;
    cur_finish = 1'b0;
    cur_wave   = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      if (idx == IW'(i)) begin
        onehot[i]  = 1'b1;
        cur_en     = voice_en[i];
        cur_finish = voice_finish[i];
        cur_wave   = voice_wave[i*24 +: 24];
      end
    end
  end

  assign at_end = (idx == IW'(N_VOICES));
  assign clr    = (state == SCAN && !at_end && cur_en) ? onehot : '0;
  assign sel_en = (state == START) || (state == WAIT);
  assign busy   = (state != IDLE);

  always_comb begin
    acc_sat = acc[23:0];
    if (acc > SAT_MAX)      acc_sat = 24'sh7FFFFF;
    else if (acc < SAT_MIN) acc_sat = 24'sh800000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      acc           <= '0;
      voice_start   <= '0;
      voice_trigger <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
    end else begin
      voice_start   <= '0;
      voice_trigger <= '0;
      sample_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= SCAN;
            idx   <= '0;
            acc   <= '0;
          end
        end
        SCAN: begin
          if (at_end) begin
            state        <= OUT;
            sample_out   <= acc_sat;
            sample_valid <= 1'b1;
          end else if (cur_en) begin
            state         <= START;
            voice_start   <= onehot;
            voice_trigger <= onehot & pending;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (cur_finish) begin
            acc   <= acc + AW'(cur_wave);
            idx   <= idx + IW'(1);
            state <= SCAN;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A note-on arriving on the clearing edge wins, so it plays next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= ((pending & ~clr) | trig_in) & voice_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_count <= '0;
    else if (sample_tick && state != IDLE && overrun_count != '1)
      overrun_count <= overrun_count + OVR_W'(1);
  end

  voice_mux #(.N(N_VOICES), .W(MULT_W), .IW(IW)) u_mux_ma (
    .sel(idx), .en(sel_en), .data(voice_mult_a), .q(mult_a));
  voice_mux #(.N(N_VOICES), .W(MULT_W), .IW(IW)) u_mux_mb (
    .sel(idx), .en(sel_en), .data(voice_mult_b), .q(mult_b));
  voice_mux #(.N(N_VOICES), .W(DIV_W), .IW(IW)) u_mux_dn (
    .sel(idx), .en(sel_en), .data(voice_div_n), .q(div_n));
  voice_mux #(.N(N_VOICES), .W(DIV_W), .IW(IW)) u_mux_dd (
    .sel(idx), .en(sel_en), .data(voice_div_d), .q(div_d));

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with three stub voices of programmable
// latency, wave value and operands.
module tb_voice_scheduler;
  import synth_pkg::*;

  localparam int N = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  sample_tick;
  logic [N-1:0]          trig_in;
  logic [N-1:0]          voice_en;
  logic [N-1:0]          voice_start;
  logic [N-1:0]          voice_trigger;
  logic [N-1:0]          voice_finish;
  logic [N*MULT_W-1:0]   voice_mult_a;
  logic [N*MULT_W-1:0]   voice_mult_b;
  logic [N*DIV_W-1:0]    voice_div_n;
  logic [N*DIV_W-1:0]    voice_div_d;
  logic [N*24-1:0]       voice_wave;
  logic [MULT_W-1:0]     mult_a;
  logic [MULT_W-1:0]     mult_b;
  logic [DIV_W-1:0]      div_n;
  logic [DIV_W-1:0]      div_d;
  sample_t               sample_out;
  logic                  sample_valid;
  logic                  busy;
  logic [15:0]           overrun_count;

  int n_checks;
  int n_fail;

  // stub voice state
  int                    lat  [N];
  bit                    hang [N];
  int                    cnt  [N];
  sample_t               wave [N];
  logic [MULT_W-1:0]     op_a [N];
  logic [MULT_W-1:0]     op_b [N];
  logic [DIV_W-1:0]      op_n [N];
  logic [DIV_W-1:0]      op_d [N];

  voice_scheduler #(.N_VOICES(N), .OVR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .trig_in(trig_in),
    .voice_en(voice_en), .voice_start(voice_start), .voice_trigger(voice_trigger),
    .voice_finish(voice_finish), .voice_mult_a(voice_mult_a),
    .voice_mult_b(voice_mult_b), .voice_div_n(voice_div_n),
    .voice_div_d(voice_div_d), .voice_wave(voice_wave), .mult_a(mult_a),
    .mult_b(mult_b), .div_n(div_n), .div_d(div_d), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun_count(overrun_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub voices: finish pulses lat cycles after the start pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (voice_start[i])  cnt[i] <= lat[i];
        else if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
      end
    end
  end

  always_comb begin
    voice_finish = '0;
    voice_wave   = '0;
    voice_mult_a = '0;
    voice_mult_b = '0;
    voice_div_n  = '0;
    voice_div_d  = '0;
    for (int i = 0; i < N; i++) begin
      voice_finish[i]               = (cnt[i] == 1) && !hang[i];
      voice_wave[i*24 +: 24]        = wave[i];
      voice_mult_a[i*MULT_W +: MULT_W] = op_a[i];
      voice_mult_b[i*MULT_W +: MULT_W] = op_b[i];
      voice_div_n[i*DIV_W +: DIV_W]    = op_n[i];
      voice_div_d[i*DIV_W +: DIV_W]    = op_d[i];
    end
  end

  // driver tasks
  task automatic set_voices(input int l0, input int l1, input int l2,
                            input int w0, input int w1, input int w2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
    wave[0] = 24'(w0); wave[1] = 24'(w1); wave[2] = 24'(w2);
  endtask

  task automatic pulse_trig1();
    @(posedge clk); #1 trig_in[1] = 1'b1;
    @(posedge clk); #1 trig_in[1] = 1'b0;
  endtask

  // Pulses one tick (plus an optional second one) and records the frame.
  task automatic run_frame(input bit inj_trig1, input int second_tick,
                           output int lat_cyc, output int n_valid,
                           output sample_t smp, output logic [N-1:0] starts,
                           output logic [N-1:0] trigs);
    int post;
    lat_cyc = -1; n_valid = 0; smp = '0; starts = '0; trigs = '0; post = 0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    for (int cyc = 1; cyc < 400 && post < 4; cyc++) begin
      sample_tick = (cyc == second_tick);
      @(negedge clk);
      starts |= voice_start;
      trigs  |= voice_trigger;
      if (inj_trig1 && voice_start[1]) trig_in[1] = 1'b1;
      if (sample_valid) begin
        n_valid++;
        if (lat_cyc < 0) begin
          lat_cyc = cyc;
          smp     = sample_out;
        end
      end
      if (lat_cyc >= 0) post++;
      @(posedge clk); #1;
      trig_in     = '0;
      sample_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, sample_valid, voice_start, voice_trigger} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy=%b valid=%b start=%b trig=%b, want all 0",
               busy, sample_valid, voice_start, voice_trigger);
    end
    n_checks++;
    if (sample_out !== 24'sd0 || overrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: got sample=%0d ovr=%0d, want 0 0", sample_out, overrun_count);
    end
    n_checks++;
    if ({mult_a, mult_b, div_n, div_d} !== '0) begin
      n_fail++;
      $display("FAIL reset_mux: got mult_a=%h div_n=%h, want 0", mult_a, div_n);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    int lc, nv; sample_t s; logic [N-1:0] st, tr;
    set_voices(5, 7, 3, 100, -50, 25);
    voice_en = 3'b111;
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (s !== 24'sd75) begin
      n_fail++; $display("FAIL basic_sum: got %0d, want 75", s);
    end
    n_checks++;
    if (lc !== 23) begin
      n_fail++; $display("FAIL basic_latency: got %0d, want 23", lc);
    end
    n_checks++;
    if (nv !== 1 || st !== 3'b111) begin
      n_fail++; $display("FAIL basic_pulses: got valid=%0d starts=%b, want 1 111", nv, st);
    end
  endtask

  task automatic test_saturation();
    int lc, nv; sample_t s; logic [N-1:0] st, tr;
    set_voices(1, 1, 1, 8388607, 8388607, 8388607);
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (s !== 24'sd8388607) begin
      n_fail++; $display("FAIL sat_pos: got %0d, want 8388607", s);
    end
    set_voices(1, 1, 1, -8388608, -8388608, -8388608);
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (s !== -24'sd8388608) begin
      n_fail++; $display("FAIL sat_neg: got %0d, want -8388608", s);
    end
    set_voices(2, 2, 2, 8388607, -8388608, 1000);
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (s !== 24'sd999 || lc !== 2 + 3 * 4) begin
      n_fail++; $display("FAIL sat_mixed: got %0d lat %0d, want 999 lat 14", s, lc);
    end
  endtask

  task automatic test_trigger();
    int lc, nv; sample_t s; logic [N-1:0] st, tr;
    set_voices(5, 7, 3, 100, -50, 25);
    voice_en = 3'b111;
    pulse_trig1();
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (tr !== 3'b010) begin
      n_fail++; $display("FAIL trig_next_frame: got %b, want 010", tr);
    end
    run_frame(1'b1, 0, lc, nv, s, st, tr);
    n_checks++;
    if (tr !== 3'b000) begin
      n_fail++; $display("FAIL trig_cleared: got %b, want 000", tr);
    end
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (tr !== 3'b010) begin
      n_fail++; $display("FAIL trig_set_wins: got %b, want 010", tr);
    end
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (tr !== 3'b000) begin
      n_fail++; $display("FAIL trig_once: got %b, want 000", tr);
    end
  endtask

  task automatic test_disabled_voice();
    int lc, nv; sample_t s; logic [N-1:0] st, tr;
    set_voices(5, 7, 3, 100, -50, 25);
    voice_en = 3'b101;
    pulse_trig1();
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (st !== 3'b101) begin
      n_fail++; $display("FAIL dis_starts: got %b, want 101", st);
    end
    n_checks++;
    if (s !== 24'sd125 || lc !== 15) begin
      n_fail++; $display("FAIL dis_sum_lat: got %0d lat %0d, want 125 lat 15", s, lc);
    end
    pulse_trig1();
    voice_en = 3'b111;
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (tr !== 3'b000 || st !== 3'b111) begin
      n_fail++; $display("FAIL dis_trig_discard: got trig=%b starts=%b, want 000 111", tr, st);
    end
  endtask

  // Checks every cycle of a frame: operands follow the voice between its
  // start pulse and its finish pulse, and are 0 otherwise.
  task automatic test_operand_mux();
    int active, post, bad;
    logic [2*MULT_W+2*DIV_W-1:0] exp_v;
    set_voices(4, 6, 2, 1, 2, 3);
    voice_en = 3'b101;
    active = -1; post = 0; bad = 0;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    for (int cyc = 1; cyc < 200 && post < 3; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (voice_start[i]) active = i;
      exp_v = (active >= 0) ? {op_a[active], op_b[active], op_n[active], op_d[active]} : '0;
      n_checks++;
      if ({mult_a, mult_b, div_n, div_d} !== exp_v) begin
        n_fail++; bad++;
        if (bad < 5)
          $display("FAIL mux_cycle%0d: got mult_a=%h div_d=%h, want mult_a=%h div_d=%h",
                   cyc, mult_a, div_d, exp_v[2*MULT_W+2*DIV_W-1 -: MULT_W], exp_v[DIV_W-1:0]);
      end
      if (active >= 0 && voice_finish[active]) active = -1;
      if (sample_valid || post > 0) post++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (post == 0) begin
      n_fail++; $display("FAIL mux_frame_end: got no sample_valid, want one");
    end
  endtask

  task automatic test_overrun_and_reset();
    int lc, nv; sample_t s; logic [N-1:0] st, tr;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    set_voices(5, 7, 3, 100, -50, 25);
    voice_en = 3'b111;
    run_frame(1'b0, 4, lc, nv, s, st, tr);
    n_checks++;
    if (overrun_count !== 16'd1 || nv !== 1) begin
      n_fail++; $display("FAIL ovr_one: got ovr=%0d valid=%0d, want 1 1", overrun_count, nv);
    end
    n_checks++;
    if (s !== 24'sd75 || lc !== 23) begin
      n_fail++; $display("FAIL ovr_frame: got %0d lat %0d, want 75 lat 23", s, lc);
    end
    // hang voice 0 so the scheduler sits in WAIT, then flood ticks
    hang[0] = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b1;
    repeat (65535) @(posedge clk);
    #1 sample_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL ovr_reach_max: got %h, want ffff", overrun_count);
    end
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL ovr_saturate: got %h, want ffff", overrun_count);
    end
    n_checks++;
    if (busy !== 1'b1 || mult_a !== op_a[0]) begin
      n_fail++; $display("FAIL hang_wait: got busy=%b mult_a=%h, want 1 %h", busy, mult_a, op_a[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, sample_valid, voice_start, mult_a, div_n} !== '0 ||
        sample_out !== 24'sd0 || overrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b valid=%b mult_a=%h sample=%0d ovr=%0d, want all 0",
               busy, sample_valid, mult_a, sample_out, overrun_count);
    end
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_valid) nv++;
    end
    n_checks++;
    if (nv !== 0) begin
      n_fail++; $display("FAIL reset_no_valid: got %0d pulses, want 0", nv);
    end
    hang[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(1'b0, 0, lc, nv, s, st, tr);
    n_checks++;
    if (s !== 24'sd75 || lc !== 23 || nv !== 1) begin
      n_fail++; $display("FAIL post_reset_frame: got %0d lat %0d valid %0d, want 75 23 1", s, lc, nv);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    sample_tick = 1'b0; trig_in = '0; voice_en = 3'b111; rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      hang[i] = 1'b0; lat[i] = 1; wave[i] = '0;
      op_a[i] = 32'hA000_0001 + 32'(i * 16'h1111);
      op_b[i] = 32'hB000_0002 + 32'(i * 16'h2222);
      op_n[i] = 48'hC000_0000_0003 + 48'(i * 16'h3333);
      op_d[i] = 48'hD000_0000_0004 + 48'(i * 16'h4444);
    end
    test_reset();
    test_basic_frame();
    test_saturation();
    test_trigger();
    test_disabled_voice();
    test_operand_mux();
    test_overrun_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
